// File: rtl/mmio_responder_pkg.sv
// mmio_pkg: register offsets, event word layout and TCTRL bit positions for mmio_responder
package mmio_pkg;
    localparam logic [3:0] OFS_LED     = 4'h0;
    localparam logic [3:0] OFS_EVENT   = 4'h1;
    localparam logic [3:0] OFS_STATUS  = 4'h2;
    localparam logic [3:0] OFS_TIMER   = 4'h3;
    localparam logic [3:0] OFS_TCTRL   = 4'h4;
    localparam logic [3:0] OFS_STRIKES = 4'h5;
    localparam int TCTRL_RUN = 0;
    localparam int TCTRL_EXP = 1;
    localparam int EV_VALID  = 15;
    // EVENT read word: valid flag in the top bit, event code in the low byte
    function automatic logic [15:0] ev_word(input logic [7:0] code);
        logic [15:0] w;
        w = {8'h00, code};
        w[EV_VALID] = 1'b1;
        return w;
    endfunction
endpackage

// File: rtl/mmio_responder_event_fifo.sv
// event_fifo: circular FIFO of 8-bit event codes, pointers carry an extra wrap bit
module event_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic        do_push, do_pop;
    assign count_o = wptr_q - rptr_q;
    assign full_o  = count_o == (AW+1)'(DEPTH);
    assign empty_o = count_o == '0;
    assign data_o  = mem_q[rptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // advance each pointer by one on an accepted push/pop
    always_comb begin
        wptr_d = wptr_q + (AW+1)'(do_push);
        rptr_d = rptr_q + (AW+1)'(do_pop);
    end
    // pointer registers; clearing them empties the FIFO
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end
    // storage needs no reset: entries are only read once written
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: 16-word MMIO window with LED, event FIFO, strikes and optional countdown timer (MMIO_TIMER_EN)
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          CLK_PER_TICK = 50_000_000,
    parameter int          MAX_STRIKES  = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] wr_data,
    input  logic        we,
    input  logic        re,
    output logic        hit,
    output logic [15:0] rd_data,
    input  logic        event_valid,
    input  logic [7:0]  event_code,
    output logic        event_ready,
    output logic [15:0] led_out,
    output logic        boom
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(MAX_STRIKES + 1);
    if (BASE_ADDR[3:0] != 4'h0) begin : g_bad_base
        $error("BASE_ADDR low nibble must be zero");
    end
    if (CLK_PER_TICK < 1) begin : g_bad_tick
        $error("CLK_PER_TICK must be at least 1");
    end
    logic [3:0]    ofs;
    logic          acc_wr, acc_rd, expired;
    logic [15:0]   led_q, led_d, rd_q, rd_d, rdata;
    logic [SW-1:0] strikes_q, strikes_d;
    logic          boom_q, boom_d;
    logic [7:0]    fifo_data;
    logic [AW:0]   fifo_count;
    logic          fifo_full, fifo_empty;
    assign hit         = addr[15:4] == BASE_ADDR[15:4];
    assign ofs         = addr[3:0];
    assign acc_wr      = we && hit;
    assign acc_rd      = re && hit;
    assign event_ready = !fifo_full;
    assign led_out     = led_q;
    assign rd_data     = rd_q;
    assign boom        = boom_q;
    event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (event_valid),
        .data_i  (event_code),
        .pop_i   (acc_rd && ofs == OFS_EVENT),
        .data_o  (fifo_data),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
`ifdef MMIO_TIMER_EN
    localparam int PW = CLK_PER_TICK > 1 ? $clog2(CLK_PER_TICK) : 1;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   timer_q, timer_d;
    logic          run_q, run_d, exp_q, exp_d, wrap;
    assign wrap    = presc_q == PW'(CLK_PER_TICK - 1);
    assign expired = exp_q;
    // countdown while running; CPU stores override the tick and restart the prescaler
    always_comb begin
        presc_d = presc_q;
        timer_d = timer_q;
        run_d   = run_q;
        exp_d   = exp_q;
        if (run_q) begin
            presc_d = wrap ? '0 : presc_q + 1'b1;
            if (wrap && timer_q != 16'd0) timer_d = timer_q - 1'b1;
            if (timer_q == 16'd0 || (wrap && timer_q == 16'd1)) begin
                exp_d = 1'b1;
                run_d = 1'b0;
            end
        end
        if (acc_wr && ofs == OFS_TIMER) begin
            timer_d = wr_data;
            presc_d = '0;
        end
        if (acc_wr && ofs == OFS_TCTRL) begin
            run_d   = wr_data[TCTRL_RUN];
            presc_d = '0;
            if (wr_data[TCTRL_EXP]) exp_d = 1'b0;
        end
    end
    // timer state registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            presc_q <= '0;
            timer_q <= '0;
            run_q   <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            timer_q <= timer_d;
            run_q   <= run_d;
            exp_q   <= exp_d;
        end
    end
`else
    assign expired = 1'b0;
`endif
    // read mux over the pre-store register values
    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_LED:     rdata = led_q;
            OFS_EVENT:   rdata = fifo_empty ? 16'h0000 : ev_word(fifo_data);
            OFS_STATUS:  rdata = {11'b0, fifo_full, 4'(fifo_count)};
`ifdef MMIO_TIMER_EN
            OFS_TIMER:   rdata = timer_q;
            OFS_TCTRL: begin
                rdata[TCTRL_RUN] = run_q;
                rdata[TCTRL_EXP] = exp_q;
            end
`endif
            OFS_STRIKES: rdata = 16'(strikes_q);
            default:     rdata = '0;
        endcase
    end
    // register next state for LED, strikes, load data and detonation flag
    always_comb begin
        led_d     = (acc_wr && ofs == OFS_LED) ? wr_data : led_q;
        strikes_d = (acc_wr && ofs == OFS_STRIKES && wr_data[0] && strikes_q != SW'(MAX_STRIKES))
                    ? strikes_q + 1'b1 : strikes_q;
        rd_d      = acc_rd ? rdata : rd_q;
        boom_d    = expired || strikes_q == SW'(MAX_STRIKES);
    end
    // register state
    always_ff @(posedge clock) begin
        if (!reset) begin
            led_q     <= '0;
            strikes_q <= '0;
            rd_q      <= '0;
            boom_q    <= 1'b0;
        end else begin
            led_q     <= led_d;
            strikes_q <= strikes_d;
            rd_q      <= rd_d;
            boom_q    <= boom_d;
        end
    end
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed self-checking bench for mmio_responder
module tb_mmio_responder;
    logic        clock = 1'b0, reset = 1'b0;
    logic [15:0] addr = '0, wr_data = '0;
    logic        we = 1'b0, re = 1'b0, event_valid = 1'b0;
    logic [7:0]  event_code = '0;
    logic        hit, event_ready, boom;
    logic [15:0] rd_data, led_out;
    int          errors = 0, checks = 0;

    always #5 clock = ~clock;

    mmio_responder #(.CLK_PER_TICK(4)) dut (
        .clock(clock), .reset(reset), .addr(addr), .wr_data(wr_data), .we(we), .re(re),
        .hit(hit), .rd_data(rd_data), .event_valid(event_valid), .event_code(event_code),
        .event_ready(event_ready), .led_out(led_out), .boom(boom)
    );

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d, input int n = 1);
        addr = a; wr_data = d; we = 1'b1;
        repeat (n) @(negedge clock);
        we = 1'b0;
    endtask

    task automatic load(input logic [15:0] a, output logic [15:0] d);
        addr = a; re = 1'b1;
        @(negedge clock);
        re = 1'b0;
        d = rd_data;
    endtask

    task automatic push(input logic [7:0] c);
        event_code = c; event_valid = 1'b1;
        @(negedge clock);
        event_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        addr = 16'h0000; #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_hit: got %b want 0", hit); end
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL rst_rd: got %h want 0000", rd_data); end
        checks++; if (led_out !== 16'h0000) begin errors++; $display("FAIL rst_led: got %h want 0000", led_out); end
        checks++; if (boom !== 1'b0) begin errors++; $display("FAIL rst_boom: got %b want 0", boom); end
        checks++; if (event_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", event_ready); end
        @(negedge clock);
        reset = 1'b1;
        load(16'hFF02, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rst_status: got %h want 0000", v); end
        load(16'hFF05, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rst_strikes: got %h want 0000", v); end
    endtask

    task automatic test_led();
        logic [15:0] v;
        addr = 16'hFF00; #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_ff00: got %b want 1", hit); end
        addr = 16'hFF0F; #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_ff0f: got %b want 1", hit); end
        addr = 16'hFF10; #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_ff10: got %b want 0", hit); end
        addr = 16'hFEFF; #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_feff: got %b want 0", hit); end
        @(negedge clock);
        store(16'hFF00, 16'hA5A5);
        checks++; if (led_out !== 16'hA5A5) begin errors++; $display("FAIL led_out: got %h want a5a5", led_out); end
        load(16'hFF00, v);
        checks++; if (v !== 16'hA5A5) begin errors++; $display("FAIL led_rd: got %h want a5a5", v); end
    endtask

    task automatic test_fifo();
        logic [15:0] v;
        logic [7:0]  codes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) push(codes[i]);
        checks++; if (event_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", event_ready); end
        load(16'hFF02, v);
        checks++; if (v !== 16'h0014) begin errors++; $display("FAIL status_full: got %h want 0014", v); end
        for (int i = 0; i < 4; i++) begin
            load(16'hFF01, v);
            checks++; if (v !== {8'h80, codes[i]}) begin errors++; $display("FAIL ev_rd%0d: got %h want %h", i, v, {8'h80, codes[i]}); end
        end
        load(16'hFF01, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL ev_empty: got %h want 0000", v); end
        load(16'hFF02, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL status_empty: got %h want 0000", v); end
    endtask

    task automatic test_full_pop();
        logic [15:0] v;
        logic [15:0] exp_w [4] = '{16'h80A2, 16'h80A3, 16'h80A4, 16'h8055};
        for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i));
        event_code = 8'h55; event_valid = 1'b1; addr = 16'hFF01; re = 1'b1; #1;
        checks++; if (event_ready !== 1'b0) begin errors++; $display("FAIL fp_ready0: got %b want 0", event_ready); end
        @(negedge clock);
        re = 1'b0;
        checks++; if (rd_data !== 16'h80A1) begin errors++; $display("FAIL fp_rd: got %h want 80a1", rd_data); end
        checks++; if (event_ready !== 1'b1) begin errors++; $display("FAIL fp_ready1: got %b want 1", event_ready); end
        @(negedge clock);
        event_valid = 1'b0;
        checks++; if (event_ready !== 1'b0) begin errors++; $display("FAIL fp_refull: got %b want 0", event_ready); end
        load(16'hFF02, v);
        checks++; if (v !== 16'h0014) begin errors++; $display("FAIL fp_status: got %h want 0014", v); end
        for (int i = 0; i < 4; i++) begin
            load(16'hFF01, v);
            checks++; if (v !== exp_w[i]) begin errors++; $display("FAIL fp_drain%0d: got %h want %h", i, v, exp_w[i]); end
        end
        event_code = 8'h66; event_valid = 1'b1; addr = 16'hFF01; re = 1'b1;
        @(negedge clock);
        re = 1'b0; event_valid = 1'b0;
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL pp_empty_rd: got %h want 0000", rd_data); end
        load(16'hFF02, v);
        checks++; if (v !== 16'h0001) begin errors++; $display("FAIL pp_status: got %h want 0001", v); end
        load(16'hFF01, v);
        checks++; if (v !== 16'h8066) begin errors++; $display("FAIL pp_rd: got %h want 8066", v); end
    endtask

    task automatic test_rw_same();
        addr = 16'hFF00; wr_data = 16'h1234; we = 1'b1; re = 1'b1;
        @(negedge clock);
        we = 1'b0; re = 1'b0;
        checks++; if (rd_data !== 16'hA5A5) begin errors++; $display("FAIL rw_rd: got %h want a5a5", rd_data); end
        checks++; if (led_out !== 16'h1234) begin errors++; $display("FAIL rw_led: got %h want 1234", led_out); end
    endtask

    task automatic test_timer();
        logic [15:0] v;
`ifdef MMIO_TIMER_EN
        store(16'hFF03, 16'd2);
        load(16'hFF03, v);
        checks++; if (v !== 16'd2) begin errors++; $display("FAIL tm_set: got %h want 0002", v); end
        store(16'hFF04, 16'h0001);
        idle(4);
        load(16'hFF03, v);
        checks++; if (v !== 16'd1) begin errors++; $display("FAIL tm_one: got %h want 0001", v); end
        idle(2);
        checks++; if (boom !== 1'b0) begin errors++; $display("FAIL tm_boom_early: got %b want 0", boom); end
        idle(1);
        checks++; if (boom !== 1'b0) begin errors++; $display("FAIL tm_boom_lag: got %b want 0", boom); end
        load(16'hFF03, v);
        checks++; if (v !== 16'd0) begin errors++; $display("FAIL tm_zero: got %h want 0000", v); end
        checks++; if (boom !== 1'b1) begin errors++; $display("FAIL tm_boom: got %b want 1", boom); end
        load(16'hFF04, v);
        checks++; if (v !== 16'h0002) begin errors++; $display("FAIL tm_expired: got %h want 0002", v); end
        store(16'hFF04, 16'h0002);
        load(16'hFF04, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL tm_clear: got %h want 0000", v); end
        checks++; if (boom !== 1'b0) begin errors++; $display("FAIL tm_boom_clr: got %b want 0", boom); end
        store(16'hFF04, 16'h0001);
        load(16'hFF04, v);
        checks++; if (v !== 16'h0001) begin errors++; $display("FAIL tm_run0: got %h want 0001", v); end
        load(16'hFF04, v);
        checks++; if (v !== 16'h0002) begin errors++; $display("FAIL tm_exp0: got %h want 0002", v); end
        store(16'hFF04, 16'h0002);
        idle(2);
`else
        store(16'hFF03, 16'h1234);
        load(16'hFF03, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL notm_timer: got %h want 0000", v); end
        store(16'hFF04, 16'h0003);
        load(16'hFF04, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL notm_tctrl: got %h want 0000", v); end
        idle(2);
        checks++; if (boom !== 1'b0) begin errors++; $display("FAIL notm_boom: got %b want 0", boom); end
`endif
    endtask

    task automatic test_strikes();
        logic [15:0] v;
        store(16'hFF05, 16'h0000);
        load(16'hFF05, v);
        checks++; if (v !== 16'd0) begin errors++; $display("FAIL st_bit0: got %h want 0000", v); end
        store(16'hFF05, 16'h0001, 2);
        load(16'hFF05, v);
        checks++; if (v !== 16'd2) begin errors++; $display("FAIL st_held: got %h want 0002", v); end
        checks++; if (boom !== 1'b0) begin errors++; $display("FAIL st_boom2: got %b want 0", boom); end
        store(16'hFF05, 16'h0001);
        load(16'hFF05, v);
        checks++; if (v !== 16'd3) begin errors++; $display("FAIL st_three: got %h want 0003", v); end
        checks++; if (boom !== 1'b1) begin errors++; $display("FAIL st_boom: got %b want 1", boom); end
        store(16'hFF05, 16'h0001);
        load(16'hFF05, v);
        checks++; if (v !== 16'd3) begin errors++; $display("FAIL st_sat: got %h want 0003", v); end
    endtask

    task automatic test_miss();
        logic [15:0] v;
        addr = 16'h1230; wr_data = 16'hFFFF; we = 1'b1; re = 1'b1; #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b want 0", hit); end
        @(negedge clock);
        we = 1'b0; re = 1'b0;
        checks++; if (rd_data !== 16'h0003) begin errors++; $display("FAIL miss_rd: got %h want 0003", rd_data); end
        checks++; if (led_out !== 16'h1234) begin errors++; $display("FAIL miss_led: got %h want 1234", led_out); end
        load(16'hFF00, v);
        checks++; if (v !== 16'h1234) begin errors++; $display("FAIL miss_ledrd: got %h want 1234", v); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        push(8'h77);
        store(16'hFF00, 16'hBEEF);
        addr = 16'hFF05; wr_data = 16'h0001; we = 1'b1; re = 1'b1; reset = 1'b0;
        @(negedge clock);
        checks++; if (led_out !== 16'h0000) begin errors++; $display("FAIL mid_led: got %h want 0000", led_out); end
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL mid_rd: got %h want 0000", rd_data); end
        checks++; if (boom !== 1'b0) begin errors++; $display("FAIL mid_boom: got %b want 0", boom); end
        checks++; if (event_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", event_ready); end
        we = 1'b0; re = 1'b0; reset = 1'b1;
        load(16'hFF02, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL mid_status: got %h want 0000", v); end
        load(16'hFF05, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL mid_strikes: got %h want 0000", v); end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        test_reset();
        test_led();
        test_fifo();
        test_full_pop();
        test_rw_same();
        test_timer();
        test_strikes();
        test_miss();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
